cam_stream_tx: RTL

- OV7670-compatible pixel stream transmitter: the sending end of the camera capture interface.
- Drives P_CLOCK, VSYNC, HREF and an 8-bit DATA bus, sending RGB565 pixels as two bytes per pixel.
- Pixels come from a frame buffer read port with 1-cycle latency (M9K style).
- Used as a camera emulator on the GPIO header for bench/loopback testing of the capture/downsampler path, and as a reusable frame source.

---
 rtl/cam_pkg.sv | 46 ++++
 rtl/cam_stream_tx_if.sv | 21 ++
 rtl/cam_tx_pattern_gen.sv | 39 +++
 rtl/cam_stream_tx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670-style stream transmitter: state encoding,
// RGB565 colours and the default 176x144 frame geometry.
package cam_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC_S,
        VBACK,
        ACTIVE,
        VFRONT
    } cam_state_e;

    localparam logic [15:0] RED     = 16'hF800;
    localparam logic [15:0] GREEN   = 16'h07E0;
    localparam logic [15:0] BLUE    = 16'h001F;
    localparam logic [15:0] BLACK   = 16'h0000;
    localparam logic [15:0] WHITE   = 16'hFFFF;
    localparam logic [15:0] YELLOW  = 16'hFFE0;
    localparam logic [15:0] CYAN    = 16'h07FF;
    localparam logic [15:0] MAGENTA = 16'hF81F;

    localparam int DEF_H_ACTIVE    = 176;
    localparam int DEF_V_ACTIVE    = 144;
    localparam int DEF_H_BLANK     = 144;
    localparam int DEF_VSYNC_LINES = 3;
    localparam int DEF_V_BACK      = 17;
    localparam int DEF_V_FRONT     = 10;

    // Classic left-to-right colour bar order.
    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] c;
        c = BLACK;
        case (idx)
            3'd0: c = WHITE;
            3'd1: c = YELLOW;
            3'd2: c = CYAN;
            3'd3: c = GREEN;
            3'd4: c = MAGENTA;
            3'd5: c = RED;
            3'd6: c = BLUE;
            default: c = BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cam_stream_tx_if.sv
// Camera-side bus (P_CLOCK/VSYNC/HREF/DATA) plus the frame-buffer fetch port.
interface cam_stream_tx_if;
    logic        P_CLOCK;
    logic        VSYNC;
    logic        HREF;
    logic [7:0]  DATA;
    logic        PIX_RD_EN;
    logic [7:0]  PIX_X;
    logic [7:0]  PIX_Y;
    logic [15:0] PIX_DATA;

    modport master (
        output P_CLOCK, VSYNC, HREF, DATA, PIX_RD_EN, PIX_X, PIX_Y,
        input  PIX_DATA
    );

    modport slave (
        input  P_CLOCK, VSYNC, HREF, DATA, PIX_RD_EN, PIX_X, PIX_Y,
        output PIX_DATA
    );
endinterface

// File: rtl/cam_tx_pattern_gen.sv
// Test pattern pixel source; registers on the fetch strobe so it behaves like
// the 1-cycle-latency frame buffer it replaces.
module cam_tx_pattern_gen
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE
) (
    input  logic        CLOCK,
    input  logic        rd_en_i,
    input  logic [7:0]  x_i,
    input  logic [7:0]  y_i,
    input  logic [1:0]  sel_i,
    output logic [15:0] pix_o
);

    logic [15:0] pix_q;
    logic [15:0] pix_d;
    logic [2:0]  bar;

    always_comb begin
        bar   = 3'((32'(x_i) * 32'd8) / 32'(H_ACTIVE));
        pix_d = pix_q;
        if (rd_en_i) begin
            case (sel_i)
                2'd0:    pix_d = RED;
                2'd1:    pix_d = BLUE;
                2'd2:    pix_d = bar_colour(bar);
                default: pix_d = ((y_i % 8'd10) == 8'd0) ? RED : BLACK;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        pix_q <= pix_d;
    end

    assign pix_o = pix_q;

endmodule

// File: rtl/cam_stream_tx.sv
// OV7670-compatible RGB565 stream transmitter (two bytes per pixel, P_CLOCK = CLOCK/2).
// Define CAM_TX_PATTERN_EN to source pixels from the internal test pattern generator.
module cam_stream_tx
    import cam_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int H_BLANK     = DEF_H_BLANK,
    parameter int VSYNC_LINES = DEF_VSYNC_LINES,
    parameter int V_BACK      = DEF_V_BACK,
    parameter int V_FRONT     = DEF_V_FRONT
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic             ENABLE,
    input  logic [1:0]       PATTERN_SEL,
    cam_stream_tx_if.master  cam,
    output logic             BUSY,
    output logic             FRAME_DONE
);

    localparam logic [10:0] LAST_TICK  = 11'(2 * H_ACTIVE + H_BLANK - 1);
    localparam logic [10:0] HREF_TICKS = 11'(2 * H_ACTIVE);
    localparam logic [8:0]  VS_LAST    = 9'(VSYNC_LINES - 1);
    localparam logic [8:0]  VB_LAST    = 9'(V_BACK - 1);
    localparam logic [8:0]  VA_LAST    = 9'(V_ACTIVE - 1);
    localparam logic [8:0]  VF_LAST    = 9'(V_FRONT - 1);

    cam_state_e  state_q, state_d, nxt_state;
    logic [10:0] tick_q, tick_d, nxt_tick;
    logic [8:0]  line_q, line_d, nxt_line, cur_last;
    logic        pclk_q, pclk_d;
    logic        busy_q, busy_d;
    logic        vsync_q, vsync_d;
    logic        href_q, href_d;
    logic        done_q, done_d;
    logic        rd_q, rd_d;
    logic        fetch_dly_q;
    logic [7:0]  data_q, data_d;
    logic [7:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] src_pix;
    logic        frame_end, nxt_href, mid_line, pre_line;

`ifdef CAM_TX_PATTERN_EN
    logic [15:0] pat_pix;
    logic        unused_pix_data;

    cam_tx_pattern_gen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pattern_gen (
        .CLOCK   (CLOCK),
        .rd_en_i (rd_q),
        .x_i     (x_q),
        .y_i     (y_q),
        .sel_i   (PATTERN_SEL),
        .pix_o   (pat_pix)
    );

    assign src_pix         = pat_pix;
    assign cam.PIX_RD_EN   = 1'b0;
    assign unused_pix_data = ^cam.PIX_DATA;
`else
    logic unused_sel;

    assign src_pix       = cam.PIX_DATA;
    assign cam.PIX_RD_EN = rd_q;
    assign unused_sel    = ^PATTERN_SEL;
`endif

    // The low byte goes out straight from the source; only the high byte is replayed.
    logic unused_hold_lo;
    assign unused_hold_lo = ^hold_q[7:0];

    // Position of the next tick, and what that tick needs.
    always_comb begin
        nxt_state = state_q;
        nxt_tick  = tick_q + 11'd1;
        nxt_line  = line_q;
        frame_end = 1'b0;
        cur_last  = '0;
        case (state_q)
            VSYNC_S: cur_last = VS_LAST;
            VBACK:   cur_last = VB_LAST;
            ACTIVE:  cur_last = VA_LAST;
            VFRONT:  cur_last = VF_LAST;
            default: cur_last = '0;
        endcase
        if (tick_q == LAST_TICK) begin
            nxt_tick = '0;
            if (line_q == cur_last) begin
                nxt_line = '0;
                case (state_q)
                    VSYNC_S: nxt_state = VBACK;
                    VBACK:   nxt_state = ACTIVE;
                    ACTIVE:  nxt_state = VFRONT;
                    VFRONT: begin
                        nxt_state = VSYNC_S;
                        frame_end = 1'b1;
                    end
                    default: nxt_state = IDLE;
                endcase
            end else begin
                nxt_line = line_q + 9'd1;
            end
        end
        nxt_href = (nxt_state == ACTIVE) && (nxt_tick < HREF_TICKS);
        // Second byte of pixel n-1 fetches pixel n; the final blank tick fetches pixel 0.
        mid_line = (nxt_state == ACTIVE) && nxt_tick[0] && (nxt_tick < HREF_TICKS - 11'd1);
        pre_line = (nxt_tick == LAST_TICK) &&
                   (((nxt_state == VBACK) && (nxt_line == VB_LAST)) ||
                    ((nxt_state == ACTIVE) && (nxt_line != VA_LAST)));
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        line_d  = line_q;
        pclk_d  = pclk_q;
        busy_d  = busy_q;
        vsync_d = vsync_q;
        href_d  = href_q;
        data_d  = data_q;
        x_d     = x_q;
        y_d     = y_q;
        rd_d    = 1'b0;
        done_d  = 1'b0;
        hold_d  = fetch_dly_q ? src_pix : hold_q;
        case (state_q)
            IDLE: begin
                if (ENABLE) begin
                    state_d = VSYNC_S;
                    busy_d  = 1'b1;
                    vsync_d = 1'b1;
                    tick_d  = '0;
                    line_d  = '0;
                    pclk_d  = 1'b0;
                end
            end
            default: begin
                pclk_d = ~pclk_q;
                if (pclk_q) begin
                    if (frame_end && !ENABLE) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        tick_d  = '0;
                        line_d  = '0;
                        vsync_d = 1'b0;
                        href_d  = 1'b0;
                        data_d  = '0;
                        x_d     = '0;
                        y_d     = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = nxt_state;
                        tick_d  = nxt_tick;
                        line_d  = nxt_line;
                        vsync_d = (nxt_state == VSYNC_S);
                        href_d  = nxt_href;
                        done_d  = frame_end;
                        if (!nxt_href) begin
                            data_d = '0;
                        end else if (nxt_tick[0]) begin
                            data_d = hold_q[15:8];
                        end else begin
                            data_d = src_pix[7:0];
                        end
                        if (frame_end) begin
                            y_d = '0;
                        end
                        if ((nxt_state == ACTIVE) && (nxt_tick == HREF_TICKS)) begin
                            x_d = '0;
                        end
                        if (mid_line) begin
                            rd_d = 1'b1;
                            x_d  = 8'((nxt_tick + 11'd1) >> 1);
                            y_d  = 8'(nxt_line);
                        end
                        if (pre_line) begin
                            rd_d = 1'b1;
                            x_d  = '0;
                            y_d  = (nxt_state == ACTIVE) ? 8'(nxt_line + 9'd1) : 8'd0;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            line_q      <= '0;
            pclk_q      <= 1'b0;
            busy_q      <= 1'b0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            data_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            rd_q        <= 1'b0;
            done_q      <= 1'b0;
            fetch_dly_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            line_q      <= line_d;
            pclk_q      <= pclk_d;
            busy_q      <= busy_d;
            vsync_q     <= vsync_d;
            href_q      <= href_d;
            data_q      <= data_d;
            x_q         <= x_d;
            y_q         <= y_d;
            rd_q        <= rd_d;
            done_q      <= done_d;
            fetch_dly_q <= rd_q;
        end
        hold_q <= hold_d;
    end

    assign cam.P_CLOCK = pclk_q;
    assign cam.VSYNC   = vsync_q;
    assign cam.HREF    = href_q;
    assign cam.DATA    = data_q;
    assign cam.PIX_X   = x_q;
    assign cam.PIX_Y   = y_q;
    assign BUSY        = busy_q;
    assign FRAME_DONE  = done_q;

endmodule
